// File: rtl/dcr_dmem_arb_pkg.sv
// dcr_dmem_arb package: arbiter FSM states, core ids and the
// upper bound on data-memory read latency.
package dcr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  typedef logic core_id_t;

  localparam int MAX_MEM_LAT = 4;

endpackage

// File: rtl/dcr_dmem_arb_if.sv
// dcr_dmem_arb bus: both core MEM-stage ports plus the
// data-memory macro port, seen from the arbiter (slave).
interface dcr_dmem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              c0_req;
  logic              c0_we;
  logic [ADDR_W-1:0] c0_addr;
  logic [DATA_W-1:0] c0_wdata;
  logic [DATA_W-1:0] c0_rdata;
  logic              c0_stall;

  logic              c1_req;
  logic              c1_we;
  logic [ADDR_W-1:0] c1_addr;
  logic [DATA_W-1:0] c1_wdata;
  logic [DATA_W-1:0] c1_rdata;
  logic              c1_stall;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  c0_req, c0_we, c0_addr, c0_wdata,
    output c0_rdata, c0_stall,
    input  c1_req, c1_we, c1_addr, c1_wdata,
    output c1_rdata, c1_stall,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output c0_req, c0_we, c0_addr, c0_wdata,
    input  c0_rdata, c0_stall,
    output c1_req, c1_we, c1_addr, c1_wdata,
    input  c1_rdata, c1_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dcr_dmem_arb_rr_pick2.sv
// dcr_rr_pick2: two-way round-robin picker; on a tie the core
// that did not win last time is chosen.
module dcr_rr_pick2
  import dcr_arb_pkg::*;
(
  input  logic [1:0] req,
  input  core_id_t   last_grant,
  output logic       grant_valid,
  output core_id_t   grant_id
);

  always_comb begin
    grant_valid = |req;
    grant_id    = 1'b0;
    unique case (req)
      2'b11:   grant_id = ~last_grant;
      2'b10:   grant_id = 1'b1;
      2'b01:   grant_id = 1'b0;
      default: grant_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/dcr_dmem_arb.sv
// dcr_dmem_arb: shares one data memory between two core MEM
// stages, one access in flight, round-robin on contention.
module dcr_dmem_arb
  import dcr_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input logic           clk,
  input logic           rst,
  dcr_dmem_arb_if.slave bus
);

  localparam int LAT_W = $clog2(MAX_MEM_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_END = LAT_W'(MEM_LAT);

  if (MEM_LAT < 1 || MEM_LAT > MAX_MEM_LAT) begin : gLatChk
    $error("dcr_dmem_arb: MEM_LAT out of range");
  end

  arb_state_t        state;
  core_id_t          sel;
  core_id_t          lastGrant;
  core_id_t          grantId;
  logic              grantValid;
  logic [LAT_W-1:0]  latCnt;
  logic              memEn;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic [DATA_W-1:0] c0Rdata;
  logic [DATA_W-1:0] c1Rdata;

  dcr_rr_pick2 uPick (
    .req        ({bus.c1_req, bus.c0_req}),
    .last_grant (lastGrant),
    .grant_valid(grantValid),
    .grant_id   (grantId)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 1'b0;
      lastGrant <= 1'b1;
      latCnt    <= '0;
      memEn     <= 1'b0;
      memWe     <= 1'b0;
      memAddr   <= '0;
      memWdata  <= '0;
      c0Rdata   <= '0;
      c1Rdata   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grantValid) begin
            sel      <= grantId;
            memEn    <= 1'b1;
            memWe    <= grantId ? bus.c1_we : bus.c0_we;
            memAddr  <= grantId ? bus.c1_addr : bus.c0_addr;
            memWdata <= grantId ? bus.c1_wdata : bus.c0_wdata;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          memEn <= 1'b0;
          if (memWe) begin
            state <= DONE;
          end else begin
            latCnt <= LAT_W'(1);
            state  <= WAIT;
          end
        end
        WAIT: begin
          // latCnt tracks which cycle after mem_en we are in
          if (latCnt == LAT_END) begin
            if (sel) c1Rdata <= bus.mem_rdata;
            else     c0Rdata <= bus.mem_rdata;
            state <= DONE;
          end else begin
            latCnt <= latCnt + LAT_W'(1);
          end
        end
        DONE: begin
          lastGrant <= sel;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // stall drops only in the owning core's DONE cycle
  assign bus.c0_stall = bus.c0_req && !(state == DONE && sel == 1'b0);
  assign bus.c1_stall = bus.c1_req && !(state == DONE && sel == 1'b1);

  assign bus.mem_en    = memEn;
  assign bus.mem_we    = memWe;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign bus.c0_rdata  = c0Rdata;
  assign bus.c1_rdata  = c1Rdata;

endmodule
